// File: rtl/bin_to_bcd_scan.sv
// Serial binary-to-BCD converter (double dabble, one bit per clock) feeding a
// time-multiplexed digit bus with a one-hot select delayed to match the 7-seg decoder.
module bin_to_bcd_scan #(
  parameter int unsigned BinW       = 13,
  parameter int unsigned Digits     = 4,
  parameter int unsigned RefreshDiv = 1000,
  parameter int unsigned DecLat     = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  input  logic [BinW-1:0]     in_data_i,
  output logic                in_ready_o,
  output logic                result_valid_o,
  output logic [4*Digits-1:0] bcd_out_o,
  output logic [3:0]          digit_o,
  output logic [Digits-1:0]   digit_sel_o
);

  localparam int unsigned BcdW      = 4 * Digits;
  localparam int unsigned CntW      = $clog2(BinW + 1);
  localparam int unsigned IdxW      = (Digits > 1) ? $clog2(Digits) : 1;
  localparam int unsigned RefW      = (RefreshDiv > 1) ? $clog2(RefreshDiv) : 1;
  localparam int unsigned SelStages = DecLat + 1;

  localparam logic [RefW-1:0] RefMax = RefW'(RefreshDiv - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(Digits - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [BinW-1:0] shift_q;
  logic [BcdW-1:0] scratch_q;
  logic [BcdW-1:0] bcd_q;
  logic [CntW-1:0] cnt_q;
  logic            rv_q;
  logic [BcdW-1:0] adj;

  // Add-3 correction applied before every shift so each nibble stays decimal.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < Digits; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      rv_q      <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            shift_q   <= in_data_i;
            scratch_q <= '0;
            cnt_q     <= CntW'(BinW);
            state_q   <= StShift;
          end
        end
        StShift: begin
          scratch_q <= BcdW'({adj, shift_q[BinW-1]});
          shift_q   <= shift_q << 1;
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StDone;
        end
        StDone: begin
          bcd_q   <= scratch_q;
          rv_q    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [RefW-1:0]   refresh_q;
  logic [IdxW-1:0]   index_q;
  logic [3:0]        digit_q;
  logic [3:0]        digit_d;
  logic [Digits-1:0] sel_onehot;
  logic [Digits-1:0] sel_pipe_q [SelStages];

  always_comb begin
    digit_d    = '0;
    sel_onehot = '0;
    for (int i = 0; i < Digits; i++) begin
      if (index_q == IdxW'(i)) begin
        digit_d       = bcd_q[4*i +: 4];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // One stage mirrors the digit register, the rest cover the decoder latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      refresh_q <= '0;
      index_q   <= '0;
      digit_q   <= '0;
      for (int s = 0; s < SelStages; s++) sel_pipe_q[s] <= Digits'(1);
    end else begin
      if (refresh_q == RefMax) begin
        refresh_q <= '0;
        index_q   <= (index_q == IdxMax) ? '0 : index_q + 1'b1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      digit_q       <= digit_d;
      sel_pipe_q[0] <= sel_onehot;
      for (int s = 1; s < SelStages; s++) sel_pipe_q[s] <= sel_pipe_q[s-1];
    end
  end

  assign in_ready_o     = (state_q == StIdle);
  assign result_valid_o = rv_q;
  assign bcd_out_o      = bcd_q;
  assign digit_o        = digit_q;
  assign digit_sel_o    = sel_pipe_q[SelStages-1];

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Directed bench for bin_to_bcd_scan: scoreboard of expected BCD results,
// latency/throughput timing, scan order and digit_sel alignment, mid-run reset.
module tb_bin_to_bcd_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_data = '0;
  logic        in_ready;
  logic        result_valid;
  logic [15:0] bcd_out;
  logic [3:0]  digit;
  logic [3:0]  digit_sel;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [15:0] sb_q [$];
  int rv_times [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_scan #(
    .BinW      (13),
    .Digits    (4),
    .RefreshDiv(4),
    .DecLat    (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_ready_o    (in_ready),
    .result_valid_o(result_valid),
    .bcd_out_o     (bcd_out),
    .digit_o       (digit),
    .digit_sel_o   (digit_sel)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      check("rv_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) check("bcd_out", 32'(bcd_out), 32'(sb_q.pop_front()));
      rv_times.push_back(cyc);
    end
  end

  // Entered and left on a negedge; single-cycle in_valid.
  task automatic send_one(input int v);
    logic [15:0] prev;
    int low;
    prev = bcd_out;
    check("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 13'(v);
    sb_q.push_back(to_bcd(v));
    @(negedge clk);
    in_valid = 1'b0;
    low = 0;
    while (!in_ready && low < 40) begin
      low++;
      if (low == 7) check("bcd_hold", 32'(bcd_out), 32'(prev));
      @(negedge clk);
    end
    check("ready_low_cycles", 32'(low), 32'd14);
    check("rv_at_ready", 32'(result_valid), 32'd1);
    @(negedge clk);
    check("rv_one_cycle", 32'(result_valid), 32'd0);
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 80) begin
      n++;
      @(negedge clk);
    end
    check("drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int i;
    int j;
    int idx;
    int vals [3];
    logic [15:0] b;
    logic [3:0] prev_digit;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single conversions, including min and max
    send_one(1234);
    send_one(0);
    send_one(8191);
    check("bcd_max", 32'(bcd_out), 32'h8191);

    // in_valid held; data changes while busy must not be taken
    in_valid = 1'b1;
    in_data  = 13'd42;
    sb_q.push_back(to_bcd(42));
    @(negedge clk);
    in_data = 13'd77;
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("held_ready_back", 32'(in_ready), 32'd1);
    sb_q.push_back(to_bcd(77));
    @(negedge clk);
    in_valid = 1'b0;
    wait_drained();

    // Scan order and digit_sel alignment with static 1234
    send_one(1234);
    b = to_bcd(1234);
    prev_digit = digit;
    n = 0;
    @(negedge clk);
    while (!(digit == 4'd4 && prev_digit == 4'd1) && n < 40) begin
      prev_digit = digit;
      n++;
      @(negedge clk);
    end
    check("scan_sync", 32'(n < 40), 32'd1);
    for (int k = 0; k < 18; k++) begin
      check("scan_digit", 32'(digit), 32'(b[4*((k/4)%4) +: 4]));
      j = k - 2;
      idx = (j < 0) ? 3 : (j / 4) % 4;
      check("scan_sel", 32'(digit_sel), 32'(4'b0001 << idx));
      @(negedge clk);
    end

    // Reset mid-conversion
    in_valid = 1'b1;
    in_data  = 13'd5000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", 32'(bcd_out), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sel", 32'(digit_sel), 32'd1);
    check("mid_rst_digit", 32'(digit), 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_ready_hold", 32'(in_ready), 32'd1);
    check("mid_rst_sel_hold", 32'(digit_sel), 32'd1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_bcd", 32'(bcd_out), 32'd0);
    send_one(4321);

    // Back-to-back with in_valid held: spacing of result pulses
    vals[0] = 9;
    vals[1] = 10;
    vals[2] = 99;
    rv_times.delete();
    in_valid = 1'b1;
    in_data  = 13'(vals[0]);
    i = 0;
    n = 0;
    while (i < 3 && n < 100) begin
      if (in_ready) begin
        sb_q.push_back(to_bcd(vals[i]));
        i++;
        @(negedge clk);
        if (i < 3) in_data = 13'(vals[i]);
      end else begin
        @(negedge clk);
      end
      n++;
    end
    in_valid = 1'b0;
    wait_drained();
    check("b2b_pulses", 32'(rv_times.size()), 32'd3);
    if (rv_times.size() == 3) begin
      check("b2b_gap1", 32'(rv_times[1] - rv_times[0]), 32'd15);
      check("b2b_gap2", 32'(rv_times[2] - rv_times[1]), 32'd15);
    end
    check("bcd_last", 32'(bcd_out), 32'h0099);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
